alu_input_sequencer: RTL

- Control stage directly upstream of the registered 16-bit ALU (A/B/OpCode/Result registers with load_A, load_B, load_Op, updateRes strobes).
- Turns human button presses plus switch data into single-cycle load strobes and a registered data bus, in the fixed order A → B → OpCode → result update.
- Contains an input synchroniser, an optional debouncer, an edge detector and a 5-state FSM.
- Sits between board buttons/switches and the ALU register block.

---
 rtl/alu_input_sequencer.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_input_sequencer.sv
// alu_input_sequencer
// Control stage in front of the registered 16-bit ALU. Converts raw button
// presses plus switch data into single-cycle load strobes and a registered
// data bus, in the fixed order A -> B -> OpCode -> result update.
//
// Optional feature macro: ALU_SEQ_DEBOUNCE_EN
//   defined   : each synchronised button passes through a stable-level
//               debouncer of DEBOUNCE_CYCLES cycles before edge detection.
//   undefined : synchronised level feeds the edge detector directly.
//
// Ports:
//   clk        in   system clock, posedge
//   reset      in   asynchronous active-high reset
//   enter_btn  in   raw "accept" button
//   back_btn   in   raw "previous step" button
//   data_sw    in   [N-1:0] raw switch value
//   data_out   out  [N-1:0] registered capture of data_sw (ALU data_in)
//   load_A     out  1-cycle strobe, data_out holds operand A
//   load_B     out  1-cycle strobe, data_out holds operand B
//   load_Op    out  1-cycle strobe, data_out[1:0] holds OpCode
//   updateRes  out  1-cycle strobe, ALU captures result and flags
//   step       out  [2:0] one-hot LED position (001 A, 010 B, 100 Op, 000 else)
//   busy       out  high while in UPDATE
//
// Handshake: there is no back-pressure. Each strobe is a single-cycle
// valid pulse, qualified by data_out in the same cycle; the ALU is assumed
// always ready to capture.
module alu_input_sequencer #(
    parameter int N               = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enter_btn,
    input  logic         back_btn,
    input  logic [N-1:0] data_sw,
    output logic [N-1:0] data_out,
    output logic         load_A,
    output logic         load_B,
    output logic         load_Op,
    output logic         updateRes,
    output logic [2:0]   step,
    output logic         busy
);

    localparam logic [2:0] ST_WAIT_A  = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_UPDATE  = 3'd3;
    localparam logic [2:0] ST_SHOW    = 3'd4;

    // A non-positive debounce length is meaningless; this empty block only
    // makes such a configuration visible in the elaborated hierarchy.
    if (DEBOUNCE_CYCLES < 1) begin : g_invalid_debounce_cycles
    end

    // ---------------- 2-flop synchronisers ----------------
    logic enter_s1_q, enter_s2_q, back_s1_q, back_s2_q;
    logic enter_s1_d, enter_s2_d, back_s1_d, back_s2_d;

    always_comb begin
        enter_s1_d = enter_btn;
        enter_s2_d = enter_s1_q;
        back_s1_d  = back_btn;
        back_s2_d  = back_s1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_s1_q <= 1'b0;
            enter_s2_q <= 1'b0;
            back_s1_q  <= 1'b0;
            back_s2_q  <= 1'b0;
        end else begin
            enter_s1_q <= enter_s1_d;
            enter_s2_q <= enter_s2_d;
            back_s1_q  <= back_s1_d;
            back_s2_q  <= back_s2_d;
        end
    end

    // ---------------- optional debouncer ----------------
    logic enter_lvl, back_lvl;

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          enter_db_q, enter_db_d, back_db_q, back_db_d;
    logic [CW-1:0] enter_cnt_q, enter_cnt_d, back_cnt_q, back_cnt_d;

    // The accepted level flips only after DEBOUNCE_CYCLES consecutive cycles
    // of disagreement; any cycle of agreement (a bounce) restarts the count.
    always_comb begin
        enter_db_d  = enter_db_q;
        enter_cnt_d = '0;
        if (enter_s2_q != enter_db_q) begin
            if (enter_cnt_q == CNT_LAST) begin
                enter_db_d = enter_s2_q;
            end else begin
                enter_cnt_d = enter_cnt_q + 1'b1;
            end
        end
        back_db_d  = back_db_q;
        back_cnt_d = '0;
        if (back_s2_q != back_db_q) begin
            if (back_cnt_q == CNT_LAST) begin
                back_db_d = back_s2_q;
            end else begin
                back_cnt_d = back_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_db_q  <= 1'b0;
            enter_cnt_q <= '0;
            back_db_q   <= 1'b0;
            back_cnt_q  <= '0;
        end else begin
            enter_db_q  <= enter_db_d;
            enter_cnt_q <= enter_cnt_d;
            back_db_q   <= back_db_d;
            back_cnt_q  <= back_cnt_d;
        end
    end

    assign enter_lvl = enter_db_q;
    assign back_lvl  = back_db_q;
`else
    assign enter_lvl = enter_s2_q;
    assign back_lvl  = back_s2_q;
`endif

    // ---------------- rising-edge detectors ----------------
    logic enter_prev_q, enter_prev_d, back_prev_q, back_prev_d;
    logic enter_evt, back_evt;

    always_comb begin
        enter_prev_d = enter_lvl;
        back_prev_d  = back_lvl;
    end

    assign enter_evt = enter_lvl & ~enter_prev_q;
    assign back_evt  = back_lvl & ~back_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_prev_q <= 1'b0;
            back_prev_q  <= 1'b0;
        end else begin
            enter_prev_q <= enter_prev_d;
            back_prev_q  <= back_prev_d;
        end
    end

    // ---------------- sequencing FSM ----------------
    logic [2:0]   state_q, state_d;
    logic [N-1:0] data_out_q, data_out_d;
    logic         load_a_q, load_a_d, load_b_q, load_b_d;
    logic         load_op_q, load_op_d, update_res_q, update_res_d;
    logic         busy_q, busy_d;

    // Enter is tested first in every state, so a simultaneous back is dropped.
    always_comb begin
        state_d      = state_q;
        data_out_d   = data_out_q;
        load_a_d     = 1'b0;
        load_b_d     = 1'b0;
        load_op_d    = 1'b0;
        update_res_d = 1'b0;
        case (state_q)
            ST_WAIT_A: begin
                if (enter_evt) begin
                    data_out_d = data_sw;
                    load_a_d   = 1'b1;
                    state_d    = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (enter_evt) begin
                    data_out_d = data_sw;
                    load_b_d   = 1'b1;
                    state_d    = ST_WAIT_OP;
                end else if (back_evt) begin
                    state_d = ST_WAIT_A;
                end
            end
            ST_WAIT_OP: begin
                if (enter_evt) begin
                    data_out_d = data_sw;
                    load_op_d  = 1'b1;
                    state_d    = ST_UPDATE;
                end else if (back_evt) begin
                    state_d = ST_WAIT_B;
                end
            end
            // One cycle after load_Op so the ALU's OpCode register is already
            // valid when it captures the result; events here are ignored.
            ST_UPDATE: begin
                update_res_d = 1'b1;
                state_d      = ST_SHOW;
            end
            ST_SHOW: begin
                if (enter_evt) begin
                    state_d = ST_WAIT_A;
                end else if (back_evt) begin
                    state_d = ST_WAIT_OP;
                end
            end
            default: state_d = ST_WAIT_A;
        endcase
        busy_d = (state_d == ST_UPDATE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_WAIT_A;
            data_out_q   <= '0;
            load_a_q     <= 1'b0;
            load_b_q     <= 1'b0;
            load_op_q    <= 1'b0;
            update_res_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_out_q   <= data_out_d;
            load_a_q     <= load_a_d;
            load_b_q     <= load_b_d;
            load_op_q    <= load_op_d;
            update_res_q <= update_res_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_WAIT_A:  step = 3'b001;
            ST_WAIT_B:  step = 3'b010;
            ST_WAIT_OP: step = 3'b100;
            default:    step = 3'b000;
        endcase
    end

    assign data_out  = data_out_q;
    assign load_A    = load_a_q;
    assign load_B    = load_b_q;
    assign load_Op   = load_op_q;
    assign updateRes = update_res_q;
    assign busy      = busy_q;

endmodule
